// File: rtl/bsg_reset_sequencer.sv
// bsg_reset_sequencer
//
// Staged reset-release controller. All downstream domains are held in reset,
// then released one at a time in ascending index order. After each release
// the controller waits for that domain's ack and then a fixed settle window
// before releasing the next one. Once every domain is up, ready_r_o is set
// and software may request a full re-sequence.
//
// State table:
//   state    | meaning
//   eHold    | all domains in reset, counting the initial hold window
//   eWaitAck | domain idx_r released, waiting for domain_ack_i[idx_r]
//   eSettle  | domain idx_r acked, counting its settle window
//   eDone    | all domains released and settled; sw re-sequence accepted
//
// Ports:
//   clk_i            - clock
//   reset_i          - synchronous active-high reset
//   domain_ack_i     - per-domain init-complete, level sampled
//   sw_reset_v_i     - software re-sequence request
//   sw_reset_ready_o - high when sw_reset_v_i will be accepted
//   domain_reset_o   - per-domain reset, high holds the domain in reset
//   ready_r_o        - all domains released and settled

module bsg_reset_sequencer #(
    parameter int num_domains_p    = 4,
    parameter int lg_wait_cycles_p = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [num_domains_p-1:0] domain_ack_i,
    input  logic                     sw_reset_v_i,
    output logic                     sw_reset_ready_o,
    output logic [num_domains_p-1:0] domain_reset_o,
    output logic                     ready_r_o
);

    localparam int idx_width_lp = (num_domains_p > 1) ? $clog2(num_domains_p) : 1;
    localparam logic [idx_width_lp-1:0] last_idx_lp = idx_width_lp'(num_domains_p - 1);

    typedef enum logic [1:0] {
        eHold    = 2'd0,
        eWaitAck = 2'd1,
        eSettle  = 2'd2,
        eDone    = 2'd3
    } state_e;

    state_e                      state_r, state_n;
    logic [lg_wait_cycles_p-1:0] cnt_r, cnt_n;
    logic [idx_width_lp-1:0]     idx_r, idx_n;
    logic [num_domains_p-1:0]    reset_r, reset_n;
    logic                        ready_r, ready_n;

    logic cnt_done;
    logic ack_sel;
    logic restart;

    assign cnt_done = &cnt_r;

    // Only the ack of the domain currently being brought up matters.
    always_comb begin
        ack_sel = 1'b0;
        for (int i = 0; i < num_domains_p; i++) begin
            if (idx_r == idx_width_lp'(i)) ack_sel = domain_ack_i[i];
        end
    end

    // A hardware reset and an accepted software request behave identically.
    assign restart = reset_i | ((state_r == eDone) & sw_reset_v_i);

    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        idx_n   = idx_r;
        reset_n = reset_r;
        ready_n = ready_r;

        case (state_r)
            eHold: begin
                cnt_n = cnt_r + lg_wait_cycles_p'(1);
                if (cnt_done) begin
                    reset_n[0] = 1'b0;
                    cnt_n      = '0;
                    state_n    = eWaitAck;
                end
            end
            eWaitAck: begin
                if (ack_sel) begin
                    cnt_n   = '0;
                    state_n = eSettle;
                end
            end
            eSettle: begin
                cnt_n = cnt_r + lg_wait_cycles_p'(1);
                if (cnt_done) begin
                    cnt_n = '0;
                    if (idx_r == last_idx_lp) begin
                        ready_n = 1'b1;
                        state_n = eDone;
                    end else begin
                        idx_n   = idx_r + idx_width_lp'(1);
                        state_n = eWaitAck;
                        for (int i = 0; i < num_domains_p; i++) begin
                            if (idx_n == idx_width_lp'(i)) reset_n[i] = 1'b0;
                        end
                    end
                end
            end
            eDone: begin
                state_n = eDone;
            end
            default: begin
                state_n = eHold;
            end
        endcase

        if (restart) begin
            state_n = eHold;
            cnt_n   = '0;
            idx_n   = '0;
            reset_n = '1;
            ready_n = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        state_r <= state_n;
        cnt_r   <= cnt_n;
        idx_r   <= idx_n;
        reset_r <= reset_n;
        ready_r <= ready_n;
    end

    assign domain_reset_o   = reset_r;
    assign ready_r_o        = ready_r;
    // Not ready while reset_i is asserted, even if the state is still eDone.
    assign sw_reset_ready_o = (state_r == eDone) & ~reset_i;

endmodule

// File: tb/tb_bsg_reset_sequencer.sv
// Testbench for bsg_reset_sequencer.
// Two instances: default parameters (4 domains, N=16) and a minimal one
// (1 domain, N=2). Stimulus pushes the expected output changes (cycle and
// value) into per-instance queues; a monitor detects every change of the
// output tuple and checks it against the head of the matching queue.

module tb_bsg_reset_sequencer;

    typedef struct {
        int         cyc;
        logic [3:0] rst;
        logic       rdy;
        logic       swr;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // instance 0: defaults
    logic       reset_i, sw_v0, swr0, rdy0;
    logic [3:0] ack0, dr0;

    bsg_reset_sequencer u0 (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .domain_ack_i     (ack0),
        .sw_reset_v_i     (sw_v0),
        .sw_reset_ready_o (swr0),
        .domain_reset_o   (dr0),
        .ready_r_o        (rdy0)
    );

    // instance 1: single domain, N=2
    logic reset1, sw_v1, swr1, rdy1, ack1, dr1;

    bsg_reset_sequencer #(
        .num_domains_p    (1),
        .lg_wait_cycles_p (1)
    ) u1 (
        .clk_i            (clk),
        .reset_i          (reset1),
        .domain_ack_i     (ack1),
        .sw_reset_v_i     (sw_v1),
        .sw_reset_ready_o (swr1),
        .domain_reset_o   (dr1),
        .ready_r_o        (rdy1)
    );

    exp_t q0[$];
    exp_t q1[$];

    int   n_cmp  = 0;
    int   n_fail = 0;
    logic done   = 1'b0;

    task automatic push0(input int c, input logic [3:0] r, input logic rd, input logic s);
        exp_t e;
        e.cyc = c; e.rst = r; e.rdy = rd; e.swr = s;
        q0.push_back(e);
    endtask

    task automatic push1(input int c, input logic r, input logic rd, input logic s);
        exp_t e;
        e.cyc = c; e.rst = {3'b000, r}; e.rdy = rd; e.swr = s;
        q1.push_back(e);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Default-parameter sequence with acks already high, events up to offset 'upto'.
    task automatic expect_seq(input int e0, input int upto);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] v;
            v = 4'hf << (i + 1);
            if (16 + i * 17 <= upto) push0(e0 + 16 + i * 17, v, 1'b0, 1'b0);
        end
        if (84 <= upto) push0(e0 + 84, 4'h0, 1'b1, 1'b1);
    endtask

    // One-cycle reset pulse on instance 0. From eDone, sw_reset_ready_o must
    // drop as soon as reset_i rises, before the edge.
    task automatic pulse_reset(input logic from_done, output int e0);
        reset_i = 1'b1;
        if (from_done) push0(cyc, 4'h0, 1'b1, 1'b0);
        @(negedge clk);
        reset_i = 1'b0;
        e0 = cyc;
        push0(e0, 4'hf, 1'b0, 1'b0);
    endtask

    task automatic check_event(input string name, input logic have, input exp_t e,
                               input logic [3:0] r, input logic rd, input logic s);
        n_cmp++;
        if (!have) begin
            n_fail++;
            $display("FAIL %s unexpected change: got rst=%b rdy=%b swr=%b at cycle %0d, required no change",
                     name, r, rd, s, cyc);
        end else if (e.cyc != cyc || e.rst !== r || e.rdy !== rd || e.swr !== s) begin
            n_fail++;
            $display("FAIL %s event: got rst=%b rdy=%b swr=%b at cycle %0d, required rst=%b rdy=%b swr=%b at cycle %0d",
                     name, r, rd, s, cyc, e.rst, e.rdy, e.swr, e.cyc);
        end
    endtask

    // monitor
    logic [5:0] prev0 = '1;
    logic [5:0] prev1 = '1;

    always begin
        logic [5:0] cur0, cur1;
        exp_t       e;
        logic       have;
        @(negedge clk);
        #1;
        if (cyc > 5000) begin
            n_cmp++;
            n_fail++;
            $display("FAIL watchdog: reached cycle %0d, required completion before cycle 5000", cyc);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
            $finish;
        end
        cur0 = {dr0, rdy0, swr0};
        if (cur0 !== prev0) begin
            prev0 = cur0;
            have  = 1'b0;
            e     = '{0, 4'h0, 1'b0, 1'b0};
            if (q0.size() > 0) begin
                e    = q0.pop_front();
                have = 1'b1;
            end
            check_event("dut0", have, e, cur0[5:2], cur0[1], cur0[0]);
        end
        cur1 = {3'b000, dr1, rdy1, swr1};
        if (cur1 !== prev1) begin
            prev1 = cur1;
            have  = 1'b0;
            e     = '{0, 4'h0, 1'b0, 1'b0};
            if (q1.size() > 0) begin
                e    = q1.pop_front();
                have = 1'b1;
            end
            check_event("dut1", have, e, cur1[5:2], cur1[1], cur1[0]);
        end
        if (done) begin
            while (q0.size() > 0) begin
                e = q0.pop_front();
                n_cmp++;
                n_fail++;
                $display("FAIL dut0 missing event: got none, required rst=%b rdy=%b swr=%b at cycle %0d",
                         e.rst, e.rdy, e.swr, e.cyc);
            end
            while (q1.size() > 0) begin
                e = q1.pop_front();
                n_cmp++;
                n_fail++;
                $display("FAIL dut1 missing event: got none, required rst=%b rdy=%b swr=%b at cycle %0d",
                         e.rst, e.rdy, e.swr, e.cyc);
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
            $finish;
        end
    end

    // stimulus
    initial begin
        int e0;
        int e1;
        reset_i = 1'b1; sw_v0 = 1'b0; ack0 = 4'hf;
        reset1  = 1'b1; sw_v1 = 1'b0; ack1 = 1'b1;

        // reset values appear after the first edge
        push0(1, 4'hf, 1'b0, 1'b0);
        push1(1, 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        reset1  = 1'b0;
        e0 = cyc;
        expect_seq(e0, 84);
        push1(e0 + 2, 1'b0, 1'b0, 1'b0);
        push1(e0 + 5, 1'b0, 1'b1, 1'b1);
        wait_to(e0 + 90);

        // software re-sequence on both; sw held high mid-sequence is ignored
        sw_v0 = 1'b1;
        sw_v1 = 1'b1;
        @(negedge clk);
        sw_v0 = 1'b0;
        sw_v1 = 1'b0;
        e0 = cyc;
        e1 = cyc;
        push0(e0, 4'hf, 1'b0, 1'b0);
        expect_seq(e0, 84);
        push1(e1, 1'b1, 1'b0, 1'b0);
        push1(e1 + 2, 1'b0, 1'b0, 1'b0);
        push1(e1 + 5, 1'b0, 1'b1, 1'b1);
        wait_to(e0 + 5);
        sw_v0 = 1'b1;
        wait_to(e0 + 70);
        sw_v0 = 1'b0;
        wait_to(e0 + 90);

        // late ack on domain 0; ack[2] raised early
        ack0 = 4'h0;
        pulse_reset(1'b1, e0);
        push0(e0 + 16, 4'b1110, 1'b0, 1'b0);
        wait_to(e0 + 21);
        ack0 = 4'b0101;
        push0(e0 + 38, 4'b1100, 1'b0, 1'b0);
        wait_to(e0 + 38);
        ack0 = 4'b1111;
        push0(e0 + 55, 4'b1000, 1'b0, 1'b0);
        push0(e0 + 72, 4'b0000, 1'b0, 1'b0);
        push0(e0 + 89, 4'b0000, 1'b1, 1'b1);
        wait_to(e0 + 95);

        // domain 1 never acks: stall for 1000 cycles, then reset
        ack0 = 4'b1101;
        pulse_reset(1'b1, e0);
        push0(e0 + 16, 4'b1110, 1'b0, 1'b0);
        push0(e0 + 33, 4'b1100, 1'b0, 1'b0);
        wait_to(e0 + 33 + 1000);
        ack0 = 4'hf;
        pulse_reset(1'b0, e0);

        // reset pulse at E40 restarts the sequence
        expect_seq(e0, 33);
        wait_to(e0 + 39);
        pulse_reset(1'b0, e0);
        expect_seq(e0, 84);
        wait_to(e0 + 90);

        // reset and sw request together behave as reset
        reset_i = 1'b1;
        sw_v0   = 1'b1;
        push0(cyc, 4'h0, 1'b1, 1'b0);
        @(negedge clk);
        reset_i = 1'b0;
        sw_v0   = 1'b0;
        e0 = cyc;
        push0(e0, 4'hf, 1'b0, 1'b0);
        expect_seq(e0, 16);
        wait_to(e0 + 20);

        done = 1'b1;
    end

endmodule

// File: doc/bsg_reset_sequencer.md
# bsg_reset_sequencer

Staged reset-release controller. It holds `num_domains_p` downstream reset domains in reset, then releases them one at a time in index order (domain 0 first). Before each next release, the just-released domain must acknowledge, and a fixed settle window must elapse. It generalizes the single wait-after-reset counter to an ordered multi-domain bring-up, and it also supports a software-requested re-sequence once bring-up is complete.

## Interface
Parameters:
- `num_domains_p`, default 4: number of reset domains; must be >= 1.
- `lg_wait_cycles_p`, default 4: log2 of the hold/settle window, N = 2^`lg_wait_cycles_p` cycles; must be >= 1.

Ports:
- `clk_i`  in  1: the single clock.
- `reset_i`  in  1: synchronous, active-high reset.
- `domain_ack_i`  in  `num_domains_p`: bit i high means domain i reports its init is complete. Level-sampled.
- `sw_reset_v_i`  in  1: software request to re-sequence all domains.
- `sw_reset_ready_o`  out  1: high when `sw_reset_v_i` will be accepted.
- `domain_reset_o`  out  `num_domains_p`: bit i high holds domain i in reset. Registered.
- `ready_r_o`  out  1: all domains released and settled. Registered.

## Operation
- Registered state: FSM {eHold, eWaitAck, eSettle, eDone}; window counter, `lg_wait_cycles_p` bits; domain index `idx_r`, width max(1, clog2(`num_domains_p`)); reset vector `reset_r`; `ready_r_o`.
- `reset_i`=1 (any state):
  - next edge: state=eHold, counter=0, `idx_r`=0, `domain_reset_o`=all ones, `ready_r_o`=0.
  - Overrides every other input.
- eHold:
  - counter increments each cycle.
  - When the counter is all-ones: clear `reset_r[0]`, counter<=0, go to eWaitAck.
- eWaitAck:
  - Waits while `domain_ack_i[idx_r]`=0. There is no timeout; the FSM stalls indefinitely.
  - When `domain_ack_i[idx_r]`=1 is sampled: counter<=0, go to eSettle.
  - Ack bits other than `idx_r` are ignored. Acks are ignored in all other states.
- eSettle:
  - counter increments each cycle.
  - When the counter is all-ones and `idx_r`==`num_domains_p`-1: `ready_r_o`<=1, go to eDone.
  - When the counter is all-ones otherwise: `idx_r`<=`idx_r`+1, clear `reset_r[idx_r+1]`, counter<=0, go to eWaitAck.
- eDone:
  - `sw_reset_ready_o`=1 (combinational from state).
  - If `sw_reset_v_i`=1: next edge is identical to `reset_i` (all resets reasserted, `ready_r_o`=0, eHold, counter=0, `idx_r`=0).
- `sw_reset_v_i` outside eDone is ignored and not remembered.
- `sw_reset_ready_o`=0 in all other states and during `reset_i`.
- Released bits stay 0 until `reset_i` or an accepted sw reset. Bits are released strictly in ascending order, exactly once per sequence.

## Timing
- E0 is the last edge sampling `reset_i`=1, or the edge accepting a sw reset. Ek is the k-th edge after E0. Here N = 2^`lg_wait_cycles_p` and D = `num_domains_p`.
- With acks already high, domain i deasserts at edge E(N + i*(N+1)).
- `ready_r_o` rises at E(N + D*(N+1)).
- Each cycle of ack delay after release adds one cycle to all later events.
- Defaults (N=16, D=4):
  - Releases at E16, E33, E50, E67.
  - Ready at E84.
- Reset values: `domain_reset_o`=all ones, `ready_r_o`=0, `sw_reset_ready_o`=0.
- `reset_i` asserted mid-sequence: all domains are back in reset at the next edge, and the sequence restarts from E0.
- `reset_i` and `sw_reset_v_i` asserted together: treated as reset, with an identical result.
- D=1: domain 0 releases at EN, ready at E(2N+1).

## Test plan
- Defaults, `domain_ack_i`=4'b1111 throughout, `reset_i` high 3 cycles then low:
  - `domain_reset_o` goes 1111 -> 1110 at E16 -> 1100 at E33 -> 1000 at E50 -> 0000 at E67.
  - `ready_r_o` 0 -> 1 at E84.
  - `sw_reset_ready_o`=1 from E84.
- Acks low initially; raise `domain_ack_i[0]` 5 cycles after domain 0 releases (E21):
  - Domain 1 releases at E38; ready at E89.
  - Raising `domain_ack_i[2]` early, while `idx_r`=1, causes no skip.
- `domain_ack_i[1]` held 0:
  - `domain_reset_o` stays 1100 and `ready_r_o` stays 0 for 1000 cycles.
  - Asserting `reset_i` returns the output to 1111.
- `reset_i` pulsed at E40 during a default-parameter sequence:
  - Next edge gives 1111 and `ready_r_o`=0.
  - Releases recur 16, 33, 50, 67 edges after the pulse.
- After ready, `sw_reset_v_i` pulsed 1 cycle:
  - Next edge gives 1111, `ready_r_o`=0, `sw_reset_ready_o`=0.
  - Full sequence repeats with identical timing.
  - `sw_reset_v_i` held high mid-sequence has no effect.
- `num_domains_p`=1, `lg_wait_cycles_p`=1, ack high:
  - `domain_reset_o` clears at E2.
  - `ready_r_o` rises at E5 (= 2N+1 with N=2).
